regfile_flags: RTL
==================

# regfile_flags

Architectural state block for the datapath: a 32-entry × 32-bit register file plus a 4-bit status flag register. Two combinational read ports source the ALU operand buses BussA and BussB. One synchronous write port takes the ALU Output. The flag register latches the ALU's negative/zero/overflow/CarryOut outputs on command, so branch logic can read them in later cycles.

## Interface
Parameters:
- DATA_WIDTH, 32, register and bus width
- NUM_REGS, 32, number of registers; address width is fixed at 5
- ZERO_REG, 31, index of the hardwired-zero register

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- ReadRegister1  in  5  read port 1 address
- ReadRegister2  in  5  read port 2 address
- ReadData1  out  32  contents of ReadRegister1; drives BussA
- ReadData2  out  32  contents of ReadRegister2; drives BussB
- WriteRegister  in  5  write address
- WriteData  in  32  write data (ALU Output)
- RegWrite  in  1  write enable
- FlagWrite  in  1  flag-latch enable
- negativeIn, zeroIn, overflowIn, CarryOutIn  in  1 each  ALU flag outputs
- negativeFlag, zeroFlag, overflowFlag, carryFlag  out  1 each  latched flags

## Operation
- Storage: registers 0..30 are 32-bit flops; register ZERO_REG has no storage.
- Reads:
  - Purely combinational (address → 32-bit mux, per bit).
  - ReadDataN = reg[ReadRegisterN], or 0 when ReadRegisterN == ZERO_REG.
  - The two ports are independent. Both may address the same register.
- Writes:
  - At the rising edge, when RegWrite=1 and reset=0, reg[WriteRegister] ← WriteData.
  - Implemented with a 5→32 decoder gated by RegWrite.
  - A write to ZERO_REG is silently discarded; ReadData for ZERO_REG stays 0.
  - RegWrite=0: no register changes, whatever the value on WriteData.
- No write-to-read bypass. A read of the register being written returns the old value until the edge, then the new value.
- Flags:
  - At the rising edge, when FlagWrite=1 and reset=0, {negativeFlag, zeroFlag, overflowFlag, carryFlag} ← {negativeIn, zeroIn, overflowIn, CarryOutIn}.
  - With FlagWrite=0, the flags hold their values.
  - RegWrite and FlagWrite are independent and may both be asserted in the same cycle.
- Reset:
  - At a rising edge with reset=1, registers 0..30 and all four flags go to 0.
  - Reset overrides RegWrite and FlagWrite; writes presented in a reset cycle are lost.
  - Reset asserted mid-sequence clears state at the next edge. Normal writes resume on the first edge with reset=0.

## Timing
- Read latency: combinational. ReadData settles within the same cycle as an address change.
- Write latency: one edge. Data presented in cycle n is readable from cycle n+1.
- Flag latency: one edge. Flag outputs are registered, with no combinational path from the *In inputs.
- Reset values:
  - ReadData1/ReadData2 = 0 for every address after reset.
  - All flag outputs = 0.
- Before the first reset, register contents are X. The bench must reset before checking anything.
- Reset takes effect only at a clock edge. An asynchronous reset pulse between edges has no effect.

## Test plan
- Reset → all clear: assert reset for 1 cycle, sweep ReadRegister1/2 over 0..31. Required: ReadData=0 everywhere; all four flags=0.
- Write/read every register:
  - Write 32'hA5A50000+i to register i (0..30), one per cycle; read back on both ports.
  - Required: each returns its pattern, and no other register is disturbed.
- Zero register and write enable:
  - Write 32'hFFFFFFFF to reg 31. Required: ReadData=0.
  - Write 32'h12345678 to reg 5 with RegWrite=0. Required: reg 5 keeps its prior value.
- Read-during-write:
  - Reg 7 = 32'h1, then present WriteData 32'h2 to reg 7 with RegWrite=1, with ReadRegister1=7.
  - Required: ReadData1=32'h1 before the edge and 32'h2 after.
- Flag latch:
  - Drive {neg,zero,ovf,carry}=1011 with FlagWrite=1 for one edge. Then drive 0100 with FlagWrite=0.
  - Required: flags read 1,0,1,1 and hold after the second edge.
- Reset priority:
  - Present RegWrite=1 (reg 3 ← 32'hDEADBEEF) and FlagWrite=1 (flags 1111) together with reset=1.
  - Required: reg 3=0 and flags=0000 after the edge.
  - Deassert reset and repeat the write. Required: reg 3=32'hDEADBEEF.

Source files
------------

// File: rtl/regfile_flags.sv
// Architectural state for the datapath: a register file with two combinational
// read ports and one synchronous write port, plus the latched ALU status flags.
module regfile_flags #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic [4:0]            WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic                  FlagWrite,
    input  logic                  negativeIn,
    input  logic                  zeroIn,
    input  logic                  overflowIn,
    input  logic                  CarryOutIn,
    output logic                  negativeFlag,
    output logic                  zeroFlag,
    output logic                  overflowFlag,
    output logic                  carryFlag
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   write_sel;
    logic [3:0]            flags_q;
    logic [3:0]            flags_d;

    // One-hot write decoder; the hardwired-zero slot never gets a select line.
    always_comb begin
        write_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            write_sel[i] = RegWrite && (WriteRegister == 5'(i)) && (i != ZERO_REG);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == ZERO_REG) begin
                regs_d[i] = '0;
            end else if (write_sel[i]) begin
                regs_d[i] = WriteData;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (FlagWrite) begin
            flags_d = {negativeIn, zeroIn, overflowIn, CarryOutIn};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            flags_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            flags_q <= flags_d;
        end
    end

    // Reads see the registered contents only, so a same-cycle write is not bypassed.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if ((int'(ReadRegister1) != ZERO_REG) && (int'(ReadRegister1) < NUM_REGS)) begin
            ReadData1 = regs_q[ReadRegister1];
        end
        if ((int'(ReadRegister2) != ZERO_REG) && (int'(ReadRegister2) < NUM_REGS)) begin
            ReadData2 = regs_q[ReadRegister2];
        end
    end

    assign {negativeFlag, zeroFlag, overflowFlag, carryFlag} = flags_q;

endmodule
